// File: rtl/fpu_add_align.sv
// -----------------------------------------------------------------------------
// fpu_add_align
//
// Front end of the FP64 adder/subtractor. It unpacks two binary64 operands,
// orders them by magnitude, aligns the smaller significand with sticky
// collection, and adds or subtracts the significands. The result is left
// unnormalized for fpu_normalizer: carry at bit 53, hidden bit at bit 52.
// NaN/Inf operands bypass the datapath through a flagged side channel.
//
// Pipeline: two registered stages with a valid/ready handshake on both sides.
//   p1 : unpack, magnitude ordering, exponent difference, special decode
//   p2 : alignment shift, sticky, significand add/sub, result sign
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   in_valid          operands valid
//   in_ready          block accepts operands this cycle (combinational from
//                     out_ready)
//   op_a, op_b        binary64 operands
//   op_sub            1: a - b, 0: a + b
//   out_valid         result valid
//   out_ready         downstream accepts the result
//   out_sign          result sign
//   out_exponent      effective exponent of the larger operand
//   out_mantissa      raw 54-bit sum/difference
//   out_sticky        OR of all bits shifted out during alignment
//   out_special       result is NaN/Inf; out_special_value is authoritative
//   out_special_value final NaN/Inf encoding when out_special = 1
// -----------------------------------------------------------------------------
module fpu_add_align #(
  parameter int Mantissa_Size = 52,
  parameter int Exponent_Size = 11
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [Exponent_Size+Mantissa_Size:0]     op_a,
  input  logic [Exponent_Size+Mantissa_Size:0]     op_b,
  input  logic                                     op_sub,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_sign,
  output logic [Exponent_Size-1:0]                 out_exponent,
  output logic [Mantissa_Size+1:0]                 out_mantissa,
  output logic                                     out_sticky,
  output logic                                     out_special,
  output logic [Exponent_Size+Mantissa_Size:0]     out_special_value
);

  localparam int W     = 1 + Exponent_Size + Mantissa_Size;
  localparam int SIG_W = Mantissa_Size + 2;
  localparam int SH_W  = $clog2(SIG_W + 1);

  localparam logic [SH_W-1:0]          SH_MAX  = SH_W'(SIG_W);
  localparam logic [Exponent_Size-1:0] EXP_ONE = Exponent_Size'(1);
  localparam logic [W-1:0]             QNAN    =
    {1'b0, {Exponent_Size{1'b1}}, 1'b1, {(Mantissa_Size-1){1'b0}}};

  // Clamp the exponent difference to the significand width: any larger
  // shift moves the whole significand into the sticky bit anyway.
  function automatic logic [SH_W-1:0] sat_shift(input logic [Exponent_Size-1:0] d);
    if (d > Exponent_Size'(SIG_W)) begin
      return SH_MAX;
    end
    return d[SH_W-1:0];
  endfunction

  // Right-shift a significand; the upper half is the aligned value, the lower
  // half holds the bits that fell off (reduced to sticky by the caller).
  function automatic logic [2*SIG_W-1:0] align_right(input logic [SIG_W-1:0] sig,
                                                      input logic [SH_W-1:0]  sh);
    return {sig, {SIG_W{1'b0}}} >> sh;
  endfunction

  // Quiet NaN for invalid cases, otherwise signed infinity from the Inf input.
  function automatic logic [W-1:0] special_encode(input logic nan_any,
                                                  input logic inf_a,
                                                  input logic inf_b,
                                                  input logic sa,
                                                  input logic sb);
    if (nan_any || (inf_a && inf_b && (sa != sb))) begin
      return QNAN;
    end
    if (inf_a) begin
      return {sa, {Exponent_Size{1'b1}}, {Mantissa_Size{1'b0}}};
    end
    return {sb, {Exponent_Size{1'b1}}, {Mantissa_Size{1'b0}}};
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic vld_p1;
  logic vld_p2;
  logic s2_hold;

  assign s2_hold   = vld_p2 & ~out_ready;
  assign in_ready  = ~vld_p1 | ~s2_hold;
  assign out_valid = vld_p2;

  // ---------------------------------------------------------------------------
  // Stage 0 -> p1 : unpack and order by magnitude
  // ---------------------------------------------------------------------------
  logic                     sa, sb_eff;
  logic [Exponent_Size-1:0] ea, eb, ea_eff, eb_eff;
  logic [Mantissa_Size-1:0] fa, fb;
  logic [SIG_W-1:0]         sig_a, sig_b;
  logic                     a_is_l;
  logic                     exp_ones_a, exp_ones_b;
  logic                     nan_a, nan_b, inf_a, inf_b;

  assign sa     = op_a[W-1];
  assign sb_eff = op_b[W-1] ^ op_sub;
  assign ea     = op_a[W-2 -: Exponent_Size];
  assign eb     = op_b[W-2 -: Exponent_Size];
  assign fa     = op_a[Mantissa_Size-1:0];
  assign fb     = op_b[Mantissa_Size-1:0];

  // Denormals share the minimum normal exponent but carry no hidden bit.
  assign ea_eff = (ea == '0) ? EXP_ONE : ea;
  assign eb_eff = (eb == '0) ? EXP_ONE : eb;
  assign sig_a  = {1'b0, (ea != '0), fa};
  assign sig_b  = {1'b0, (eb != '0), fb};

  // The hidden bit is part of the compare so a normal at the minimum
  // exponent outranks any denormal; ties keep a as the larger operand.
  assign a_is_l = {ea_eff, sig_a} >= {eb_eff, sig_b};

  assign exp_ones_a = &ea;
  assign exp_ones_b = &eb;
  assign nan_a      = exp_ones_a & (|fa);
  assign nan_b      = exp_ones_b & (|fb);
  assign inf_a      = exp_ones_a & ~(|fa);
  assign inf_b      = exp_ones_b & ~(|fb);

  logic [SIG_W-1:0]         sig_l_p1, sig_s_p1;
  logic [Exponent_Size-1:0] exp_l_p1, shift_p1;
  logic                     sign_l_p1, sa_p1, sbe_p1, eff_sub_p1;
  logic                     special_p1;
  logic [W-1:0]             special_value_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sig_l_p1         <= a_is_l ? sig_a : sig_b;
      sig_s_p1         <= a_is_l ? sig_b : sig_a;
      exp_l_p1         <= a_is_l ? ea_eff : eb_eff;
      shift_p1         <= a_is_l ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
      sign_l_p1        <= a_is_l ? sa : sb_eff;
      sa_p1            <= sa;
      sbe_p1           <= sb_eff;
      eff_sub_p1       <= sa ^ sb_eff;
      special_p1       <= exp_ones_a | exp_ones_b;
      special_value_p1 <= special_encode(nan_a | nan_b, inf_a, inf_b, sa, sb_eff);
    end
  end

  // ---------------------------------------------------------------------------
  // p1 -> p2 : align, sticky, add/subtract, sign
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]    shamt;
  logic [2*SIG_W-1:0] shifted;
  logic [SIG_W-1:0]   sig_s_aligned;
  logic               sticky;
  logic [SIG_W-1:0]   mant;
  logic               sign_res;

  assign shamt         = sat_shift(shift_p1);
  assign shifted       = align_right(sig_s_p1, shamt);
  assign sig_s_aligned = shifted[2*SIG_W-1:SIG_W];
  assign sticky        = |shifted[SIG_W-1:0];

  // L >= S in magnitude, so the difference never borrows; both significands
  // are below 2^53, so the sum always fits the carry bit.
  assign mant = eff_sub_p1 ? (sig_l_p1 - sig_s_aligned) : (sig_l_p1 + sig_s_aligned);

  // An exact zero is negative only when both effective signs are negative.
  assign sign_res = ((mant == '0) && !sticky) ? (sa_p1 & sbe_p1) : sign_l_p1;

  logic                     sign_p2, sticky_p2, special_p2;
  logic [Exponent_Size-1:0] exp_p2;
  logic [SIG_W-1:0]         mant_p2;
  logic [W-1:0]             special_value_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2           <= 1'b0;
      sign_p2          <= 1'b0;
      exp_p2           <= '0;
      mant_p2          <= '0;
      sticky_p2        <= 1'b0;
      special_p2       <= 1'b0;
      special_value_p2 <= '0;
    end else if (!s2_hold) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sign_p2          <= special_p1 ? special_value_p1[W-1] : sign_res;
        exp_p2           <= exp_l_p1;
        mant_p2          <= mant;
        sticky_p2        <= sticky;
        special_p2       <= special_p1;
        special_value_p2 <= special_value_p1;
      end
    end
  end

  assign out_sign          = sign_p2;
  assign out_exponent      = exp_p2;
  assign out_mantissa      = mant_p2;
  assign out_sticky        = sticky_p2;
  assign out_special       = special_p2;
  assign out_special_value = special_value_p2;

endmodule
